// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: instruction/flag inputs and control outputs between the control FSM and the MIPS32 datapath.
interface mc_control_fsm_if;
    logic [31:0] IR;
    logic        EQZ;
    logic [5:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        sel1;
    logic        sel2;
    logic        sel3;
    logic        sel4;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        clr_PC;
    logic        pc_en;

    modport master (
        input  IR, EQZ,
        output opcode, rs1, rs2, rd, sel1, sel2, sel3, sel4,
        output mem_rd, mem_wr, reg_wr, clr_PC, pc_en
    );

    modport slave (
        output IR, EQZ,
        input  opcode, rs1, rs2, rd, sel1, sel2, sel3, sel4,
        input  mem_rd, mem_wr, reg_wr, clr_PC, pc_en
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the MIPS32 datapath.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             run,
    mc_control_fsm_if.master dp,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {INIT, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED} state_t;
    typedef enum logic [2:0] {C_RR, C_RI, C_LW, C_SW, C_BR, C_HLT, C_ILL} cls_t;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: return C_RR;
            6'd10, 6'd11, 6'd12:                return C_RI;
            6'd8:                               return C_LW;
            6'd9:                               return C_SW;
            6'd13, 6'd14:                       return C_BR;
            6'd63:                              return C_HLT;
            default:                            return C_ILL;
        endcase
    endfunction

    state_t      state, nxt;
    logic [31:0] ir_q, ir_nxt;
    cls_t        cls, cls_nxt;
    logic        act;

    assign cls       = classify(ir_q[31:26]);
    assign dp.opcode = ir_q[31:26];
    assign dp.rs1    = ir_q[25:21];
    assign dp.rs2    = ir_q[20:16];
    assign dp.rd     = cls == C_RR ? ir_q[15:11] : (cls == C_RI || cls == C_LW) ? ir_q[20:16] : 5'd0;
    // BEQZ (op[0]=0) takes on EQZ, BNEQZ (op[0]=1) on !EQZ; the only non-Moore output
    assign dp.sel3   = state == EXECUTE && cls == C_BR && (dp.EQZ ^ ir_q[26]);

    always_comb begin
        ir_nxt  = (state == FETCH && run) ? dp.IR : ir_q;
        cls_nxt = classify(ir_nxt[31:26]);
        case (state)
            INIT:      nxt = FETCH;
            FETCH:     nxt = run ? DECODE : FETCH;
            DECODE:    nxt = cls == C_HLT ? HALTED : EXECUTE;
            EXECUTE:   nxt = cls inside {C_LW, C_SW} ? MEMORY : cls inside {C_RR, C_RI} ? WRITEBACK : FETCH;
            MEMORY:    nxt = cls == C_LW ? WRITEBACK : FETCH;
            WRITEBACK: nxt = FETCH;
            default:   nxt = HALTED;
        endcase
        act = nxt inside {DECODE, EXECUTE, MEMORY, WRITEBACK};
    end

    // Outputs are registered from the upcoming state so every enable is a clean flop, cleared asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= INIT;
            ir_q        <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            dp.clr_PC   <= 1'b1;
            dp.sel1     <= 1'b0;
            dp.sel2     <= 1'b0;
            dp.sel4     <= 1'b0;
            dp.mem_rd   <= 1'b0;
            dp.mem_wr   <= 1'b0;
            dp.reg_wr   <= 1'b0;
            dp.pc_en    <= 1'b0;
        end else begin
            state       <= nxt;
            ir_q        <= ir_nxt;
            instr_count <= instr_count + CNT_W'(dp.pc_en);
            halted      <= nxt == HALTED;
            illegal     <= illegal | (state == DECODE && cls == C_ILL);
            dp.clr_PC   <= 1'b0;
            dp.sel1     <= act && cls_nxt inside {C_RR, C_RI, C_LW, C_SW};
            dp.sel2     <= act && cls_nxt inside {C_RI, C_LW, C_SW, C_BR};
            dp.sel4     <= act && cls_nxt inside {C_RR, C_RI, C_SW, C_BR};
            dp.mem_rd   <= nxt == MEMORY && cls_nxt == C_LW;
            dp.mem_wr   <= nxt == MEMORY && cls_nxt == C_SW;
            dp.reg_wr   <= nxt == WRITEBACK;
            dp.pc_en    <= nxt == WRITEBACK || (nxt == MEMORY && cls_nxt == C_SW)
                           || (nxt == EXECUTE && cls_nxt inside {C_BR, C_ILL});
        end
    end
endmodule
